// File: rtl/regfile_pkg.sv
// Shared sizing and well-known register numbers for the MIPS register file
// with its pending-write scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [DEF_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_sb_dec_onehot.sv
// Address to one-hot decoder with enable; all outputs low when disabled.
module dec_onehot #(
    parameter int ADDR_W = 5
) (
    input  logic                     en_i,
    input  logic [ADDR_W-1:0]        addr_i,
    output logic [(1<<ADDR_W)-1:0]   onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// MIPS general register file: one decoded write port, two bypassed read ports,
// and a scoreboard of registers still owed a result by a multi-cycle unit.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              hazard1,
    output logic              hazard2,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  pend_q, pend_d;
    logic [NREGS-1:0]  wr_hot, set_hot, clr_hot;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr_en, set_en;
    logic              hit1, hit2;

    function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + (ADDR_W+1)'(v[i]);
        end
        return c;
    endfunction

    // $0 is excluded at the decoder enables, so neither its storage nor its
    // pending bit can ever leave zero.
    assign wr_en  = we && (waddr != ZERO_A);
    assign set_en = issue && (issue_addr != ZERO_A);

    dec_onehot #(.ADDR_W(ADDR_W)) u_dec_wr (
        .en_i     (wr_en),
        .addr_i   (waddr),
        .onehot_o (wr_hot)
    );

    dec_onehot #(.ADDR_W(ADDR_W)) u_dec_set (
        .en_i     (set_en),
        .addr_i   (issue_addr),
        .onehot_o (set_hot)
    );

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREGS; i++) begin
            if (wr_hot[i]) begin
                regs_d[i] = wdata;
            end
        end
    end

    // Set is OR-ed in after the clear so a newer producer keeps the bit owed.
    always_comb begin
        clr_hot = wr_hot & pend_q;
        pend_d  = (pend_q & ~clr_hot) | set_hot;
        cnt_d   = popcount(pend_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hit1 = we && (waddr == raddr1);
    assign hit2 = we && (waddr == raddr2);

    // Outputs are forced quiet while reset is held, before the clearing edge.
    always_comb begin
        rdata1  = '0;
        rdata2  = '0;
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        if (rst_n) begin
            rdata1  = (hit1 && raddr1 != ZERO_A) ? wdata : regs_q[raddr1];
            rdata2  = (hit2 && raddr2 != ZERO_A) ? wdata : regs_q[raddr2];
            hazard1 = pend_q[raddr1] && !hit1;
            hazard2 = pend_q[raddr2] && !hit2;
        end
    end

    assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector table plus a randomized run against a behavioral model;
// pending_cnt expectations travel through a queue to the post-edge check.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata1, rdata2;
    logic        issue = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        hazard1, hazard2;
    logic [5:0]  pending_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .issue       (issue),
        .issue_addr  (issue_addr),
        .hazard1     (hazard1),
        .hazard2     (hazard2),
        .pending_cnt (pending_cnt)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        is;
        logic [4:0]  ia;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eh1;
        logic        eh2;
        logic [5:0]  ec;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] cnt_q[$];

    logic [31:0] m_regs [NUM_REGS];
    logic [31:0] m_pend;

    function automatic vec_t mk(logic rst, logic w, logic [4:0] wa, logic [31:0] wd,
                                logic [4:0] r1, logic [4:0] r2, logic is, logic [4:0] ia,
                                logic [31:0] e1, logic [31:0] e2, logic eh1, logic eh2,
                                logic [5:0] ec);
        vec_t v;
        v.rst = rst; v.we = w; v.wa = wa; v.wd = wd; v.r1 = r1; v.r2 = r2;
        v.is = is; v.ia = ia; v.e1 = e1; v.e2 = e2; v.eh1 = eh1; v.eh2 = eh2; v.ec = ec;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(vec_t v, int idx);
        logic [5:0] exp_cnt;
        @(negedge clk);
        rst_n = v.rst; we = v.we; waddr = v.wa; wdata = v.wd;
        raddr1 = v.r1; raddr2 = v.r2; issue = v.is; issue_addr = v.ia;
        #1;
        chk("rdata1", idx, rdata1, v.e1);
        chk("rdata2", idx, rdata2, v.e2);
        chk("hazard1", idx, 32'(hazard1), 32'(v.eh1));
        chk("hazard2", idx, 32'(hazard2), 32'(v.eh2));
        cnt_q.push_back(v.ec);
        @(posedge clk);
        #1;
        if (cnt_q.size() == 0) begin
            chk("cnt_queue_empty", idx, 32'd0, 32'd1);
        end else begin
            exp_cnt = cnt_q.pop_front();
            chk("pending_cnt", idx, 32'(pending_cnt), 32'(exp_cnt));
        end
    endtask

    // Behavioral reference for the random phase: expected outputs for the
    // current inputs, then the state the edge should leave behind.
    task automatic model_step(inout vec_t v);
        logic w1, w2;
        w1 = v.we && (v.wa == v.r1);
        w2 = v.we && (v.wa == v.r2);
        if (!v.rst) begin
            v.e1 = '0; v.e2 = '0; v.eh1 = 1'b0; v.eh2 = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
            m_pend = '0;
        end else begin
            v.e1  = (w1 && v.r1 != 0) ? v.wd : m_regs[v.r1];
            v.e2  = (w2 && v.r2 != 0) ? v.wd : m_regs[v.r2];
            v.eh1 = m_pend[v.r1] && !w1;
            v.eh2 = m_pend[v.r2] && !w2;
            if (v.we && v.wa != 0) begin
                m_regs[v.wa] = v.wd;
                m_pend[v.wa] = 1'b0;
            end
            if (v.is && v.ia != 0) m_pend[v.ia] = 1'b1;
        end
        v.ec = 6'($countones(m_pend));
    endtask

    initial begin
        vec_t v;
        //          rst we wa  wd            r1  r2  is ia  e1            e2            h1 h2 cnt
        vecs.push_back(mk(0, 0, 0,  32'h0,        0,  0,  0, 0,  32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 1, 5,  32'hDEADBEEF, 5,  0,  0, 0,  32'hDEADBEEF, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  32'h0,        5,  5,  0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        5,  0,  0, 0,  32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  32'h0,        5,  0,  0, 0,  32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 1, 0,  32'hFFFFFFFF, 0,  0,  0, 0,  32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  32'h0,        0,  0,  0, 0,  32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 1, 8,  32'h12345678, 0,  8,  0, 0,  32'h0,        32'h12345678, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  32'h0,        0,  8,  0, 0,  32'h0,        32'h12345678, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  32'h0,        REG_RA, 0, 1, REG_RA, 32'h0, 32'h0,        0, 0, 1));
        vecs.push_back(mk(1, 0, 0,  32'h0,        31, 8,  0, 0,  32'h0,        32'h12345678, 1, 0, 1));
        vecs.push_back(mk(1, 1, 31, 32'hAAAA5555, 31, 0,  0, 0,  32'hAAAA5555, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  32'h0,        31, 0,  0, 0,  32'hAAAA5555, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  32'h0,        9,  0,  1, 9,  32'h0,        32'h0,        0, 0, 1));
        vecs.push_back(mk(1, 1, 9,  32'h99,       9,  0,  1, 9,  32'h99,       32'h0,        0, 0, 1));
        vecs.push_back(mk(1, 0, 0,  32'h0,        9,  0,  0, 0,  32'h99,       32'h0,        1, 0, 1));
        vecs.push_back(mk(1, 1, 9,  32'h100,      9,  0,  0, 0,  32'h100,      32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  32'h0,        0,  0,  1, 3,  32'h0,        32'h0,        0, 0, 1));
        vecs.push_back(mk(1, 0, 0,  32'h0,        0,  0,  1, 4,  32'h0,        32'h0,        0, 0, 2));
        vecs.push_back(mk(1, 0, 0,  32'h0,        3,  4,  1, 7,  32'h0,        32'h0,        1, 1, 3));
        vecs.push_back(mk(0, 0, 0,  32'h0,        7,  10, 1, 10, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  32'h0,        3,  7,  0, 0,  32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  32'h0,        4,  10, 0, 0,  32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  32'h0,        9,  8,  1, 12, 32'h0,        32'h0,        0, 0, 1));
        vecs.push_back(mk(1, 0, 0,  32'h0,        12, 0,  1, 12, 32'h0,        32'h0,        1, 0, 1));
        vecs.push_back(mk(1, 1, 12, 32'h5,        12, 13, 1, 13, 32'h5,        32'h0,        0, 0, 1));
        vecs.push_back(mk(1, 0, 0,  32'h0,        12, 13, 0, 0,  32'h5,        32'h0,        0, 1, 1));
        vecs.push_back(mk(1, 1, 20, 32'h7,        20, 13, 0, 0,  32'h7,        32'h0,        0, 1, 1));
        vecs.push_back(mk(1, 0, 0,  32'h0,        0,  13, 1, 0,  32'h0,        32'h0,        0, 1, 1));
        vecs.push_back(mk(1, 1, 13, 32'hCAFE,     13, 20, 0, 0,  32'hCAFE,     32'h7,        0, 0, 0));

        foreach (vecs[i]) apply(vecs[i], i);

        // Random phase on a narrow address range so collisions are frequent.
        m_pend = '0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        for (int n = 0; n < 400; n++) begin
            v.rst = (n == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
            v.we  = $urandom_range(0, 1) != 0;
            v.wa  = 5'($urandom_range(0, 7));
            v.wd  = $urandom;
            v.r1  = 5'($urandom_range(0, 7));
            v.r2  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.is  = $urandom_range(0, 2) == 0;
            v.ia  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            model_step(v);
            apply(v, 1000 + n);
        end

        if (cnt_q.size() != 0) begin
            chk("cnt_queue_leftover", 0, 32'(cnt_q.size()), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
